// File: rtl/te_pkg.sv
// Shared widths, FSM states and window helpers for the transmission-estimation
// window sequencer.
package te_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned RGB_W      = 3 * PIX_W;
    localparam int unsigned WIN_W      = 9 * PIX_W;
    localparam int unsigned TE_LAT_DEF = 2;

    // Channel slice indices inside a packed {r, g, b} pixel.
    localparam int unsigned CH_R = 2;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 0;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } te_state_e;

    // One window column: top = two lines up, bot = current line.
    typedef struct packed {
        logic [RGB_W-1:0] top;
        logic [RGB_W-1:0] mid;
        logic [RGB_W-1:0] bot;
    } te_col_t;

    typedef struct packed {
        logic vld;
        logic last;
    } te_tok_t;

    // Packs one channel of three columns as {p9..p1}, p1 = top-left.
    function automatic logic [WIN_W-1:0] te_build_win(input te_col_t     l,
                                                      input te_col_t     m,
                                                      input te_col_t     r,
                                                      input int unsigned ch);
        return {r.bot[ch*PIX_W +: PIX_W], m.bot[ch*PIX_W +: PIX_W], l.bot[ch*PIX_W +: PIX_W],
                r.mid[ch*PIX_W +: PIX_W], m.mid[ch*PIX_W +: PIX_W], l.mid[ch*PIX_W +: PIX_W],
                r.top[ch*PIX_W +: PIX_W], m.top[ch*PIX_W +: PIX_W], l.top[ch*PIX_W +: PIX_W]};
    endfunction

endpackage

// File: rtl/te_line_buffer.sv
// Two-line buffer stored as one DEPTH-deep RAM of {line-2, line-1} words;
// asynchronous read returns the old word in the cycle it is overwritten.
module te_line_buffer
    import te_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic               i_clock,
    input  logic [AW-1:0]      i_addr,
    input  logic               i_we,
    input  logic [2*RGB_W-1:0] i_wdata,
    output logic [2*RGB_W-1:0] o_rdata
);

    logic [2*RGB_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/te_window_sequencer.sv
// Raster-to-3x3 window sequencer for the transmission-estimation datapath: drives the
// pipeline Enable, tracks interior-window tokens and returns t with valid/ready.
module te_window_sequencer
    import te_pkg::*;
#(
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned TE_LAT = TE_LAT_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    input  logic [PIX_W-1:0] i_pix_r,
    input  logic [PIX_W-1:0] i_pix_g,
    input  logic [PIX_W-1:0] i_pix_b,
    output logic             o_te_enable,
    output logic [WIN_W-1:0] o_win_r,
    output logic [WIN_W-1:0] o_win_g,
    output logic [WIN_W-1:0] o_win_b,
    input  logic [PIX_W-1:0] i_te_t,
    output logic             o_t_valid,
    input  logic             i_t_ready,
    output logic [PIX_W-1:0] o_t_data,
    output logic             o_t_last,
    output logic             o_busy,
    output logic             o_frame_done
);

    localparam int unsigned   CW       = $clog2(IMG_W);
    localparam int unsigned   RW       = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    te_state_e          r_state;
    te_state_e          w_state_nxt;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;

    logic               w_active;
    logic               w_feed;
    logic               w_stall;
    logic               w_en;
    logic               w_accept;
    logic               w_start_acc;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_last_hs;

    logic [RGB_W-1:0]   w_pix;
    logic [2*RGB_W-1:0] w_lb_rdata;
    logic [2*RGB_W-1:0] w_lb_wdata;
    te_col_t            w_col_new;
    te_col_t            r_wcol1;
    te_col_t            r_wcol2;
    logic [WIN_W-1:0]   r_win_r;
    logic [WIN_W-1:0]   r_win_g;
    logic [WIN_W-1:0]   r_win_b;

    te_tok_t            w_tok_in;
    te_tok_t            r_win_tok;
    te_tok_t            r_tok [TE_LAT];

    logic               r_t_valid;
    logic               r_t_last;
    logic [PIX_W-1:0]   r_t_data;

    // Handshake and pipeline-advance strobes.
    assign w_active    = (r_state == FILL) || (r_state == RUN) || (r_state == DRAIN);
    assign w_feed      = (r_state == FILL) || (r_state == RUN);
    assign w_stall     = r_t_valid & ~i_t_ready;
    assign w_en        = w_active & ~w_stall;
    assign w_accept    = i_pix_valid & w_en & w_feed;
    assign w_start_acc = (r_state == IDLE) & i_start;
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    assign w_last_hs   = r_t_valid & i_t_ready & r_t_last;

    assign o_te_enable = w_en;
    assign o_pix_ready = w_en & w_feed;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                o_busy = 1'b1;
                if (w_accept && w_col_last && (r_row == ROW_ONE)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (w_accept && w_col_last && w_row_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                o_busy = 1'b1;
                if (w_last_hs) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_frame_done = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || w_start_acc) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffer word is {two lines up, one line up}; on accept it shifts down a line.
    assign w_pix      = {i_pix_r, i_pix_g, i_pix_b};
    assign w_lb_wdata = {w_lb_rdata[RGB_W-1:0], w_pix};
    assign w_col_new  = '{top: w_lb_rdata[2*RGB_W-1:RGB_W], mid: w_lb_rdata[RGB_W-1:0], bot: w_pix};

    te_line_buffer #(
        .DEPTH (IMG_W)
    ) u_line_buffer (
        .i_clock (i_clock),
        .i_addr  (r_col),
        .i_we    (w_accept),
        .i_wdata (w_lb_wdata),
        .o_rdata (w_lb_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wcol1 <= '0;
            r_wcol2 <= '0;
            r_win_r <= '0;
            r_win_g <= '0;
            r_win_b <= '0;
        end else if (w_accept) begin
            r_wcol2 <= r_wcol1;
            r_wcol1 <= w_col_new;
            r_win_r <= te_build_win(r_wcol2, r_wcol1, w_col_new, CH_R);
            r_win_g <= te_build_win(r_wcol2, r_wcol1, w_col_new, CH_G);
            r_win_b <= te_build_win(r_wcol2, r_wcol1, w_col_new, CH_B);
        end
    end

    assign o_win_r = r_win_r;
    assign o_win_g = r_win_g;
    assign o_win_b = r_win_b;

    // Only interior windows carry a token; an enabled cycle without a pixel injects a bubble.
    assign w_tok_in = '{vld:  w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO),
                        last: w_accept && w_col_last && w_row_last};

    always_ff @(posedge i_clock) begin
        if (i_reset || w_start_acc) begin
            r_win_tok <= '0;
            for (int unsigned i = 0; i < TE_LAT; i++) begin
                r_tok[i] <= '0;
            end
        end else if (w_en) begin
            r_win_tok <= w_tok_in;
            r_tok[0]  <= r_win_tok;
            for (int unsigned i = 1; i < TE_LAT; i++) begin
                r_tok[i] <= r_tok[i-1];
            end
        end
    end

    // Output stage advances with the datapath, so it holds while downstream stalls.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_t_valid <= 1'b0;
            r_t_last  <= 1'b0;
            r_t_data  <= '0;
        end else if (w_en) begin
            r_t_valid <= r_tok[TE_LAT-1].vld;
            r_t_last  <= r_tok[TE_LAT-1].vld & r_tok[TE_LAT-1].last;
            r_t_data  <= i_te_t;
        end
    end

    assign o_t_valid = r_t_valid;
    assign o_t_last  = r_t_last;
    assign o_t_data  = r_t_data;

endmodule

// File: tb/tb_te_window_sequencer.sv
// Directed bench for te_window_sequencer on a 5x4 frame with a two-stage ~min9 datapath model.
module tb_te_window_sequencer;

    localparam int unsigned W     = 5;
    localparam int unsigned H     = 4;
    localparam int unsigned LAT   = 2;
    localparam int          N_PIX = 20;
    localparam int          N_OUT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        te_enable;
    logic [71:0] win_r;
    logic [71:0] win_g;
    logic [71:0] win_b;
    logic [7:0]  te_t;
    logic        t_valid;
    logic        t_ready;
    logic [7:0]  t_data;
    logic        t_last;
    logic        busy;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Pixel value = row*5+col; interior window min is its top-left, so t = ~that.
    logic [7:0] exp_t [N_OUT] = '{8'd255, 8'd254, 8'd253, 8'd250, 8'd249, 8'd248};

    always #5 clk = ~clk;

    te_window_sequencer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .TE_LAT (LAT)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_pix_valid  (pix_valid),
        .o_pix_ready  (pix_ready),
        .i_pix_r      (pix_r),
        .i_pix_g      (pix_g),
        .i_pix_b      (pix_b),
        .o_te_enable  (te_enable),
        .o_win_r      (win_r),
        .o_win_g      (win_g),
        .o_win_b      (win_b),
        .i_te_t       (te_t),
        .o_t_valid    (t_valid),
        .i_t_ready    (t_ready),
        .o_t_data     (t_data),
        .o_t_last     (t_last),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    function automatic logic [7:0] min9(input logic [71:0] w);
        logic [7:0] m = w[7:0];
        for (int k = 1; k < 9; k++) begin
            if (w[k*8 +: 8] < m) m = w[k*8 +: 8];
        end
        return m;
    endfunction

    logic [7:0] dp1;
    logic [7:0] dp2;
    always_ff @(posedge clk) begin
        if (rst) begin
            dp1 <= 8'd0;
            dp2 <= 8'd0;
        end else if (te_enable) begin
            dp1 <= ~min9(win_r);
            dp2 <= dp1;
        end
    end
    assign te_t = dp2;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         cyc = 0;
    logic [8:0] beats [$];
    int         done_cnt = 0;
    int         last_cyc = -1;
    int         done_cyc = -1;
    int         acc_cnt  = 0;
    bit         win_done = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records handshaken beats and checks the first interior window.
    initial forever begin
        @(negedge clk);
        if (!busy) begin
            acc_cnt  = 0;
            win_done = 0;
        end else begin
            if (acc_cnt == 13 && !win_done) begin
                check("win_r_p5", win_r[39:32], 72'd6);
                check("win_g_p5", win_g[39:32], 72'd6);
                check("win_g_p1", win_g[7:0], 72'd0);
                check("win_r_p3", win_r[23:16], 72'd2);
                check("win_g_p7", win_g[55:48], 72'd10);
                check("win_b_p9", win_b[71:64], 72'd12);
                win_done = 1;
            end
            if (pix_valid && pix_ready) acc_cnt++;
        end
        if (t_valid && t_ready) begin
            beats.push_back({t_last, t_data});
            if (t_last) last_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_pixels(input int n, input int pct);
        int i     = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 1000) begin
            pix_valid = ($urandom_range(99) < pct);
            pix_r     = 8'(i);
            pix_g     = 8'(i);
            pix_b     = 8'(i);
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        pix_valid = 1'b0;
        check("pixels_accepted", i, n);
    endtask

    task automatic clear_mon();
        beats.delete();
        done_cnt = 0;
        last_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic finish_frame(input string tag);
        int guard = 0;
        while (done_cnt == 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_beats"}, beats.size(), N_OUT);
        for (int k = 0; k < N_OUT; k++) begin
            if (k < beats.size()) begin
                check($sformatf("%s_data%0d", tag, k), beats[k][7:0], exp_t[k]);
                check($sformatf("%s_last%0d", tag, k), beats[k][8], (k == N_OUT - 1));
            end
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_cyc - last_cyc, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_valid_end"}, t_valid, 0);
        clear_mon();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_r     = 8'd0;
        pix_g     = 8'd0;
        pix_b     = 8'd0;
        t_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_te_enable", te_enable, 0);
        check("rst_t_valid", t_valid, 0);
        check("rst_t_last", t_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_win_r", win_r, 0);
        check("rst_win_b", win_b, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_te_enable", te_enable, 0);

        // Back-to-back frame with downstream always ready.
        do_start();
        send_pixels(N_PIX, 100);
        finish_frame("s1");

        // Downstream stall on the first beat while pixels are still streaming.
        do_start();
        fork
            send_pixels(N_PIX, 100);
            begin
                int g = 0;
                while (!t_valid && g < 200) begin
                    @(posedge clk); #1;
                    g++;
                end
                t_ready = 1'b0;
                check("s3_valid_seen", t_valid, 1);
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check($sformatf("s3_en%0d", s), te_enable, 0);
                    check($sformatf("s3_rdy%0d", s), pix_ready, 0);
                    check($sformatf("s3_vld%0d", s), t_valid, 1);
                    check($sformatf("s3_data%0d", s), t_data, 8'd255);
                    check($sformatf("s3_last%0d", s), t_last, 0);
                    @(posedge clk); #1;
                end
                t_ready = 1'b1;
            end
        join
        finish_frame("s3");

        // Sparse input: bubbles must never surface as beats.
        do_start();
        send_pixels(N_PIX, 50);
        finish_frame("s4");

        // Reset with interior tokens in flight, then a clean frame.
        do_start();
        send_pixels(14, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("s5_t_valid", t_valid, 0);
        check("s5_busy", busy, 0);
        check("s5_pix_ready", pix_ready, 0);
        check("s5_te_enable", te_enable, 0);
        @(posedge clk); #1;
        clear_mon();
        do_start();
        send_pixels(N_PIX, 100);
        finish_frame("s5");

        // Start pulsed mid-frame is ignored; a following frame repeats exactly.
        do_start();
        fork
            send_pixels(N_PIX, 100);
            begin
                repeat (6) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        finish_frame("s6a");
        do_start();
        send_pixels(N_PIX, 100);
        finish_frame("s6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
